bp_fe_ltb_update_queue: RTL and testbench

//  Upstream feeder for the loop termination buffer (LTB) write port. Buffers

---
 rtl/bp_fe_ltb_update_queue.sv | 206 ++++++++++++++++++++
 tb/tb_bp_fe_ltb_update_queue.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_ltb_update_queue.sv
// ---------------------------------------------------------------------------
// bp_fe_ltb_update_queue
//
// Purpose:
//   Feeds the loop termination buffer (LTB) write port. Resolved branch
//   updates from the backend redirect path are buffered in a small FIFO and
//   the head entry is offered to the LTB with a valid/yumi handshake. Updates
//   are held back while the LTB is still initialising. If the LTB keeps
//   refusing the head (read/write index conflict), r_hold_o asks fetch to
//   stop issuing LTB reads so the write can get through.
//
// Parameters:
//   vaddr_width_p    branch address width (from the processor configuration)
//   els_p            FIFO depth, power of 2, >= 2
//   starve_cycles_p  consecutive refused cycles before r_hold_o rises, >= 1
//
// Ports:
//   clk_i             clock, rising edge
//   reset_i           asynchronous, active-high reset
//   init_done_i       LTB initialisation complete
//   enq_v_i           backend update valid
//   enq_ready_o       queue can accept an update (not full)
//   enq_mispredict_i  update payload: branch mispredicted
//   enq_taken_i       update payload: branch resolved taken
//   enq_src_addr_i    update payload: branch PC
//   deq_v_o           head entry valid (to LTB w_v_i)
//   deq_mispredict_o  head payload: mispredicted
//   deq_taken_o       head payload: taken
//   deq_src_addr_o    head payload: branch PC
//   deq_yumi_i        LTB consumed the head this cycle
//   count_o           number of buffered entries
//   r_hold_o          request fetch to suppress LTB reads (registered)
//
// Configuration macro:
//   BP_FE_LTB_UPDQ_BYPASS_EN  when defined, an update arriving at an empty
//                             queue is presented on the deq side in the same
//                             cycle; if consumed right away it is never
//                             written into storage.
// ---------------------------------------------------------------------------
module bp_fe_ltb_update_queue #(
  parameter int vaddr_width_p   = 39,
  parameter int els_p           = 4,
  parameter int starve_cycles_p = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         init_done_i,

  input  logic                         enq_v_i,
  output logic                         enq_ready_o,
  input  logic                         enq_mispredict_i,
  input  logic                         enq_taken_i,
  input  logic [vaddr_width_p-1:0]     enq_src_addr_i,

  output logic                         deq_v_o,
  output logic                         deq_mispredict_o,
  output logic                         deq_taken_o,
  output logic [vaddr_width_p-1:0]     deq_src_addr_o,
  input  logic                         deq_yumi_i,

  output logic [$clog2(els_p+1)-1:0]   count_o,
  output logic                         r_hold_o
);

  localparam int ptr_w_lp   = $clog2(els_p);
  localparam int cnt_w_lp   = $clog2(els_p + 1);
  localparam int stall_w_lp = $clog2(starve_cycles_p + 1);

  localparam logic [cnt_w_lp-1:0]   full_count_lp = cnt_w_lp'(els_p);
  localparam logic [stall_w_lp-1:0] starve_lp     = stall_w_lp'(starve_cycles_p);

  typedef struct packed {
    logic                     mispredict;
    logic                     taken;
    logic [vaddr_width_p-1:0] src_addr;
  } entry_s;

  typedef enum logic [1:0] {
    e_idle,
    e_wait,
    e_starve
  } state_e;

  entry_s                mem [els_p];
  entry_s                enq_entry;
  entry_s                head_entry;
  logic [ptr_w_lp-1:0]   rptr;
  logic [ptr_w_lp-1:0]   wptr;
  logic [cnt_w_lp-1:0]   count_r;
  logic                  empty;
  logic                  bypass;
  logic                  mem_write;
  logic                  mem_read;
  logic                  stall;

  state_e                state;
  logic [stall_w_lp-1:0] stall_cnt;
  logic [stall_w_lp-1:0] stall_cnt_inc;

  assign enq_entry = '{mispredict: enq_mispredict_i,
                       taken:      enq_taken_i,
                       src_addr:   enq_src_addr_i};

  assign empty       = (count_r == '0);
  assign enq_ready_o = (count_r != full_count_lp);
  assign count_o     = count_r;

`ifdef BP_FE_LTB_UPDQ_BYPASS_EN
  // An update arriving at an empty queue is visible to the LTB immediately.
  assign bypass = empty & enq_v_i & init_done_i;
`else
  assign bypass = 1'b0;
`endif

  assign deq_v_o    = (~empty & init_done_i) | bypass;
  assign head_entry = bypass ? enq_entry : mem[rptr];

  assign deq_mispredict_o = head_entry.mispredict;
  assign deq_taken_o      = head_entry.taken;
  assign deq_src_addr_o   = head_entry.src_addr;

  // A bypassed update consumed in its arrival cycle never touches storage.
  assign mem_write = enq_v_i & enq_ready_o & ~(bypass & deq_yumi_i);
  assign mem_read  = deq_yumi_i & ~empty & init_done_i;

  assign stall         = deq_v_o & ~deq_yumi_i;
  assign stall_cnt_inc = stall_cnt + stall_w_lp'(1);

  // NOTE: payload storage has no reset; the pointers and count alone decide
  // which entries are meaningful, so resetting the array would only add
  // reset fan-out.
  always_ff @(posedge clk_i) begin
    if (mem_write) begin
      mem[wptr] <= enq_entry;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr    <= '0;
      wptr    <= '0;
      count_r <= '0;
    end else begin
      if (mem_write) wptr <= wptr + ptr_w_lp'(1);
      if (mem_read)  rptr <= rptr + ptr_w_lp'(1);
      case ({mem_write, mem_read})
        2'b10:   count_r <= count_r + cnt_w_lp'(1);
        2'b01:   count_r <= count_r - cnt_w_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Starvation tracker. stall_cnt holds the number of consecutive stalled
  // cycles seen so far; the transition to e_starve happens on the cycle that
  // completes starve_cycles_p of them, so r_hold_o is high from the next one.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= e_idle;
      stall_cnt <= '0;
      r_hold_o  <= 1'b0;
    end else if (!init_done_i) begin
      state     <= e_idle;
      stall_cnt <= '0;
      r_hold_o  <= 1'b0;
    end else begin
      case (state)
        e_idle, e_wait: begin
          if (stall) begin
            if (stall_cnt_inc == starve_lp) begin
              state    <= e_starve;
              r_hold_o <= 1'b1;
            end else begin
              state    <= e_wait;
            end
            stall_cnt <= stall_cnt_inc;
          end else begin
            state     <= e_idle;
            stall_cnt <= '0;
            r_hold_o  <= 1'b0;
          end
        end
        e_starve: begin
          if (!stall) begin
            state     <= e_idle;
            stall_cnt <= '0;
            r_hold_o  <= 1'b0;
          end
        end
        default: begin
          state     <= e_idle;
          stall_cnt <= '0;
          r_hold_o  <= 1'b0;
        end
      endcase
    end
  end

  // The LTB may only consume an entry that is being offered.
  yumi_needs_valid: assert property (
    @(posedge clk_i) disable iff (reset_i) deq_yumi_i |-> deq_v_o
  );

endmodule

// File: tb/tb_bp_fe_ltb_update_queue.sv
// ---------------------------------------------------------------------------
// tb_bp_fe_ltb_update_queue
//
// Self-checking bench for bp_fe_ltb_update_queue. Inputs change on the
// falling edge and outputs are compared 1 ns later; the reference model is a
// plain queue of updates plus a count of consecutive stalled cycles.
// ---------------------------------------------------------------------------
module tb_bp_fe_ltb_update_queue;

  localparam int VA     = 39;
  localparam int ELS    = 4;
  localparam int STARVE = 8;
`ifdef BP_FE_LTB_UPDQ_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct packed {
    logic          m;
    logic          t;
    logic [VA-1:0] a;
  } ent_t;

  logic          clk;
  logic          reset_i;
  logic          init_done;
  logic          enq_v;
  logic          enq_ready;
  logic          enq_m;
  logic          enq_t;
  logic [VA-1:0] enq_a;
  logic          deq_v;
  logic          deq_m;
  logic          deq_t;
  logic [VA-1:0] deq_a;
  logic          yumi;
  logic [2:0]    count;
  logic          r_hold;

  int   checks;
  int   errors;
  int   stall_run;
  ent_t mq[$];

  bp_fe_ltb_update_queue #(
    .vaddr_width_p  (VA),
    .els_p          (ELS),
    .starve_cycles_p(STARVE)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .init_done_i     (init_done),
    .enq_v_i         (enq_v),
    .enq_ready_o     (enq_ready),
    .enq_mispredict_i(enq_m),
    .enq_taken_i     (enq_t),
    .enq_src_addr_i  (enq_a),
    .deq_v_o         (deq_v),
    .deq_mispredict_o(deq_m),
    .deq_taken_o     (deq_t),
    .deq_src_addr_o  (deq_a),
    .deq_yumi_i      (yumi),
    .count_o         (count),
    .r_hold_o        (r_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic ent_t rand_ent();
    ent_t e;
    e.m = 1'($urandom_range(0, 1));
    e.t = 1'($urandom_range(0, 1));
    e.a = VA'({$urandom(), $urandom()});
    return e;
  endfunction

  function automatic logic m_deq_v();
    return init_done && (mq.size() != 0 || (BYP && enq_v));
  endfunction

  function automatic ent_t m_head();
    ent_t e;
    if (mq.size() != 0) e = mq[0];
    else                e = '{m: enq_m, t: enq_t, a: enq_a};
    return e;
  endfunction

  task automatic drive(input logic ev, input ent_t e, input logic y, input logic init);
    @(negedge clk);
    enq_v = ev;
    {enq_m, enq_t, enq_a} = e;
    yumi = y;
    init_done = init;
    #1;
  endtask

  // Applies the effect of the currently driven inputs to the model, then
  // lets the rising edge happen.
  task automatic advance();
    logic v;
    logic acc;
    ent_t e;
    v   = m_deq_v();
    acc = enq_v && (mq.size() != ELS);
    e   = '{m: enq_m, t: enq_t, a: enq_a};
    if (!(yumi && v && mq.size() == 0)) begin
      if (yumi && v) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    stall_run = (v && !yumi) ? stall_run + 1 : 0;
    @(posedge clk);
  endtask

  task automatic model_clear();
    mq.delete();
    stall_run = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_i = 1'b1; init_done = 1'b0; enq_v = 1'b0; yumi = 1'b0;
    enq_m = 1'b0; enq_t = 1'b0; enq_a = '0;
    model_clear();
    #12;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", enq_ready); end
    checks++; if (deq_v !== 1'b0) begin errors++; $display("FAIL reset_deq_v: got %b expected 0", deq_v); end
    checks++; if (r_hold !== 1'b0) begin errors++; $display("FAIL reset_r_hold: got %b expected 0", r_hold); end
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  task automatic test_single();
    ent_t e;
    e = '{m: 1'b1, t: 1'b1, a: VA'(64'h1000)};
    drive(1'b1, e, 1'b0, 1'b1);
    checks++; if (deq_v !== BYP) begin errors++; $display("FAIL single_enq_cycle_v: got %b expected %b", deq_v, BYP); end
    advance();
    drive(1'b0, rand_ent(), 1'b1, 1'b1);
    checks++; if (deq_v !== 1'b1) begin errors++; $display("FAIL single_deq_v: got %b expected 1", deq_v); end
    checks++; if ({deq_m, deq_t, deq_a} !== e) begin errors++; $display("FAIL single_payload: got %b %b %h expected %b %b %h", deq_m, deq_t, deq_a, e.m, e.t, e.a); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
    advance();
    drive(1'b0, rand_ent(), 1'b0, 1'b1);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_drained_count: got %0d expected 0", count); end
    checks++; if (deq_v !== 1'b0) begin errors++; $display("FAIL single_drained_v: got %b expected 0", deq_v); end
    advance();
  endtask

  task automatic test_fill_drain();
    ent_t exp_e [ELS];
    for (int i = 0; i < ELS; i++) begin
      exp_e[i] = rand_ent();
      drive(1'b1, exp_e[i], 1'b0, 1'b1);
      advance();
    end
    drive(1'b1, rand_ent(), 1'b0, 1'b1);
    checks++; if (count !== 3'(ELS)) begin errors++; $display("FAIL fill_count: got %0d expected %0d", count, ELS); end
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b expected 0", enq_ready); end
    advance();
    drive(1'b0, rand_ent(), 1'b0, 1'b1);
    checks++; if (count !== 3'(ELS)) begin errors++; $display("FAIL fill_refused_count: got %0d expected %0d", count, ELS); end
    advance();
    for (int i = 0; i < ELS; i++) begin
      drive(1'b0, rand_ent(), 1'b1, 1'b1);
      checks++;
      if (deq_v !== 1'b1 || {deq_m, deq_t, deq_a} !== exp_e[i]) begin
        errors++;
        $display("FAIL drain_order[%0d]: got v=%b %b %b %h expected v=1 %b %b %h", i, deq_v, deq_m, deq_t, deq_a, exp_e[i].m, exp_e[i].t, exp_e[i].a);
      end
      advance();
    end
    drive(1'b0, rand_ent(), 1'b0, 1'b1);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", count); end
    advance();
  endtask

  task automatic test_full_enq_yumi();
    ent_t exp_e [ELS];
    for (int i = 0; i < ELS; i++) begin
      exp_e[i] = rand_ent();
      drive(1'b1, exp_e[i], 1'b0, 1'b1);
      advance();
    end
    drive(1'b1, rand_ent(), 1'b1, 1'b1);
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_yumi_ready: got %b expected 0", enq_ready); end
    advance();
    drive(1'b0, rand_ent(), 1'b0, 1'b1);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_yumi_count: got %0d expected 3", count); end
    advance();
    for (int i = 1; i < ELS; i++) begin
      drive(1'b0, rand_ent(), 1'b1, 1'b1);
      checks++;
      if ({deq_m, deq_t, deq_a} !== exp_e[i]) begin
        errors++;
        $display("FAIL full_yumi_order[%0d]: got %h expected %h", i, deq_a, exp_e[i].a);
      end
      advance();
    end
  endtask

  task automatic test_init_hold();
    ent_t e0;
    e0 = rand_ent();
    drive(1'b1, e0, 1'b0, 1'b0);
    advance();
    drive(1'b1, rand_ent(), 1'b0, 1'b0);
    advance();
    for (int k = 0; k < STARVE + 4; k++) begin
      drive(1'b0, rand_ent(), 1'b0, 1'b0);
      checks++;
      if (deq_v !== 1'b0 || r_hold !== 1'b0) begin
        errors++;
        $display("FAIL init_hold[%0d]: got v=%b hold=%b expected v=0 hold=0", k, deq_v, r_hold);
      end
      advance();
    end
    drive(1'b0, rand_ent(), 1'b1, 1'b1);
    checks++; if (deq_v !== 1'b1) begin errors++; $display("FAIL init_release_v: got %b expected 1", deq_v); end
    checks++; if (deq_a !== e0.a) begin errors++; $display("FAIL init_release_head: got %h expected %h", deq_a, e0.a); end
    advance();
    drive(1'b0, rand_ent(), 1'b1, 1'b1);
    advance();
  endtask

  task automatic test_starve();
    drive(1'b1, rand_ent(), 1'b0, 1'b0);
    advance();
    for (int k = 1; k <= STARVE + 3; k++) begin
      drive(1'b0, rand_ent(), 1'b0, 1'b1);
      checks++;
      if (r_hold !== (k > STARVE)) begin
        errors++;
        $display("FAIL starve_cycle[%0d]: got %b expected %b", k, r_hold, (k > STARVE));
      end
      advance();
    end
    drive(1'b0, rand_ent(), 1'b1, 1'b1);
    checks++; if (r_hold !== 1'b1) begin errors++; $display("FAIL starve_yumi_cycle: got %b expected 1", r_hold); end
    advance();
    drive(1'b0, rand_ent(), 1'b0, 1'b1);
    checks++; if (r_hold !== 1'b0) begin errors++; $display("FAIL starve_release: got %b expected 0", r_hold); end
    advance();
  endtask

`ifdef BP_FE_LTB_UPDQ_BYPASS_EN
  task automatic test_bypass();
    ent_t e;
    e = rand_ent();
    drive(1'b1, e, 1'b1, 1'b1);
    checks++; if (deq_v !== 1'b1) begin errors++; $display("FAIL bypass_v: got %b expected 1", deq_v); end
    checks++; if ({deq_m, deq_t, deq_a} !== e) begin errors++; $display("FAIL bypass_payload: got %h expected %h", deq_a, e.a); end
    advance();
    drive(1'b0, rand_ent(), 1'b0, 1'b1);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL bypass_count: got %0d expected 0", count); end
    checks++; if (deq_v !== 1'b0) begin errors++; $display("FAIL bypass_after_v: got %b expected 0", deq_v); end
    advance();
  endtask
`endif

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rand_ent(), 1'b0, 1'b1);
      advance();
    end
    drive(1'b0, rand_ent(), 1'b1, 1'b1);
    advance();
    drive(1'b0, rand_ent(), 1'b0, 1'b1);
    #2 reset_i = 1'b1;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_reset_count: got %0d expected 0", count); end
    checks++; if (deq_v !== 1'b0) begin errors++; $display("FAIL mid_reset_v: got %b expected 0", deq_v); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b expected 1", enq_ready); end
    model_clear();
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  task automatic test_random();
    int   pct [4] = '{60, 0, 95, 30};
    int   p;
    logic ev;
    logic init;
    logic v;
    logic y;
    ent_t e;
    ent_t h;
    for (int n = 0; n < 400; n++) begin
      p    = pct[(n / 40) % 4];
      ev   = 1'($urandom_range(0, 1));
      init = ($urandom_range(0, 19) != 0);
      e    = rand_ent();
      v    = init && (mq.size() != 0 || (BYP && ev));
      y    = v && ($urandom_range(0, 99) < p);
      drive(ev, e, y, init);
      checks++;
      if ({deq_v, count, enq_ready, r_hold} !==
          {m_deq_v(), 3'(mq.size()), (mq.size() != ELS), (stall_run >= STARVE)}) begin
        errors++;
        $display("FAIL random_ctrl[%0d]: got v=%b cnt=%0d rdy=%b hold=%b expected v=%b cnt=%0d rdy=%b hold=%b",
                 n, deq_v, count, enq_ready, r_hold, m_deq_v(), mq.size(), (mq.size() != ELS), (stall_run >= STARVE));
      end
      if (deq_v) begin
        h = m_head();
        checks++;
        if ({deq_m, deq_t, deq_a} !== h) begin
          errors++;
          $display("FAIL random_payload[%0d]: got %b %b %h expected %b %b %h", n, deq_m, deq_t, deq_a, h.m, h.t, h.a);
        end
      end
      advance();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_fill_drain();
    test_full_enq_yumi();
    test_init_hold();
    test_starve();
`ifdef BP_FE_LTB_UPDQ_BYPASS_EN
    test_bypass();
`endif
    test_reset_mid();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
